// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
//
// Ports:
//   clock     in   system clock, rising-edge
//   reset     in   synchronous active-high reset; aborts any conversion in flight
//   start     in   request conversion of bin; sampled only while ready = 1
//   bin       in   [BIN_WIDTH-1:0] unsigned operand, captured on the accepted start edge
//   ready     out  high only when idle
//   bcd       out  [4*BCD_DIGITS-1:0] result, digit 0 in [3:0]; held until the next valid
//   valid     out  one-cycle pulse when bcd/overflow update
//   overflow  out  last result exceeded 10^BCD_DIGITS - 1; held with bcd
//
// Optional build macro BIN_TO_BCD_BLANK_EN: leading zero digits (above digit 0) of the
// loaded result are replaced by 4'hF, the seven-segment blank code.

module bin_to_bcd_seq #(
  parameter int unsigned BIN_WIDTH  = 8,
  parameter int unsigned BCD_DIGITS = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    bin,
  output logic                    ready,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    valid,
  output logic                    overflow
);

  localparam int unsigned DigW = 4 * BCD_DIGITS;
  localparam int unsigned CntW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                  state_q, state_d;
  logic [BIN_WIDTH-1:0]    bin_q, bin_d, bin_shift;
  logic [DigW-1:0]         dig_q, dig_d, dig_adj, dig_shift;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    ovf_q, ovf_d, ovf_next;
  logic [DigW-1:0]         bcd_q, bcd_d;
  logic                    overflow_q, overflow_d;
  logic [DigW-1:0]         result;
  logic [DigW+BIN_WIDTH-1:0] shift_w;

  // Add-3 correction so each digit carries correctly into its neighbour on the shift.
  always_comb begin
    dig_adj = dig_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    shift_w   = {dig_adj, bin_q} << 1;
    dig_shift = shift_w[DigW+BIN_WIDTH-1 -: DigW];
    bin_shift = shift_w[BIN_WIDTH-1:0];
    // A set MSB in the adjusted top digit is a carry out of the digit register;
    // dropping it leaves the value modulo 10^BCD_DIGITS.
    ovf_next  = ovf_q | dig_adj[DigW-1];
  end

`ifdef BIN_TO_BCD_BLANK_EN
  // Blank every zero digit above the most significant non-zero one; digit 0 always shows.
  always_comb begin
    logic seen;
    result = dig_shift;
    seen   = 1'b0;
    for (int i = int'(BCD_DIGITS) - 1; i >= 1; i--) begin
      if (!seen && (dig_shift[4*i +: 4] == 4'd0)) begin
        result[4*i +: 4] = 4'hF;
      end else begin
        seen = 1'b1;
      end
    end
  end
`else
  assign result = dig_shift;
`endif

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bin_d   = bin;
          dig_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        bin_d = bin_shift;
        dig_d = dig_shift;
        ovf_d = ovf_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          bcd_d      = result;
          overflow_d = ovf_next;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      dig_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      dig_q      <= dig_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign valid    = (state_q == StDone);
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: a 3-digit and a 2-digit instance, scoreboard queues
// filled at stimulus time from a decimal reference model, popped by per-instance monitors.
module tb_bin_to_bcd_seq;

  logic        clock = 1'b0;
  logic        reset, start, start2;
  logic [7:0]  bin, bin2;
  logic        ready, valid, overflow;
  logic        ready2, valid2, overflow2;
  logic [11:0] bcd;
  logic [7:0]  bcd2;

  always #5 clock = ~clock;

  bin_to_bcd_seq #(.BIN_WIDTH(8), .BCD_DIGITS(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .ready    (ready),
    .bcd      (bcd),
    .valid    (valid),
    .overflow (overflow)
  );

  bin_to_bcd_seq #(.BIN_WIDTH(8), .BCD_DIGITS(2)) dut2 (
    .clock    (clock),
    .reset    (reset),
    .start    (start2),
    .bin      (bin2),
    .ready    (ready2),
    .bcd      (bcd2),
    .valid    (valid2),
    .overflow (overflow2)
  );

  typedef struct packed {
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   checks    = 0;
  int   errors    = 0;
  int   valid_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  // Decimal reference: digits by division, overflow by magnitude compare.
  function automatic void ref_model(input int unsigned v, input int digits,
                                    output logic [31:0] r, output logic ovf);
    longint unsigned p = 1;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'((longint'(v) / p) % 10);
      p = p * 10;
    end
    ovf = (longint'(v) >= p);
`ifdef BIN_TO_BCD_BLANK_EN
    for (int i = digits - 1; i >= 1; i--) begin
      if (r[4*i +: 4] != 4'd0) break;
      r[4*i +: 4] = 4'hF;
    end
`endif
  endfunction

  always @(negedge clock) begin
    if (valid === 1'b1) begin
      valid_cnt++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut_unexpected_valid actual bcd %h required no valid", bcd);
      end else begin
        e1 = q1.pop_front();
        check("dut_bcd", 32'(bcd), e1.bcd);
        check("dut_overflow", 32'(overflow), 32'(e1.ovf));
      end
    end
  end

  always @(negedge clock) begin
    if (valid2 === 1'b1) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut2_unexpected_valid actual bcd %h required no valid", bcd2);
      end else begin
        e2 = q2.pop_front();
        check("dut2_bcd", 32'(bcd2), e2.bcd);
        check("dut2_overflow", 32'(overflow2), 32'(e2.ovf));
      end
    end
  end

  task automatic wait_ready1();
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL dut_ready_timeout actual ready %b required 1", ready);
    end
  endtask

  task automatic convert1(input logic [7:0] v);
    logic [31:0] r;
    logic        o;
    wait_ready1();
    start = 1'b1;
    bin   = v;
    ref_model(v, 3, r, o);
    q1.push_back('{bcd: r, ovf: o});
    @(negedge clock);
    start = 1'b0;
    bin   = 8'($urandom); // operand already captured; must not disturb the result
  endtask

  task automatic convert2(input logic [7:0] v);
    logic [31:0] r;
    logic        o;
    int          n = 0;
    while (ready2 !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL dut2_ready_timeout actual ready %b required 1", ready2);
    end
    start2 = 1'b1;
    bin2   = v;
    ref_model(v, 2, r, o);
    q2.push_back('{bcd: r, ovf: o});
    @(negedge clock);
    start2 = 1'b0;
    bin2   = 8'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        o;
    int          v0;
    int          n;

    reset = 1'b1; start = 1'b0; start2 = 1'b0; bin = '0; bin2 = '0;
    repeat (3) @(negedge clock);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_ready2", 32'(ready2), 32'd1);
    check("reset_bcd2", 32'(bcd2), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Latency/handshake timing for 255.
    start = 1'b1;
    bin   = 8'd255;
    ref_model(255, 3, r, o);
    q1.push_back('{bcd: r, ovf: o});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k <= 9) check($sformatf("lat_ready_c%0d", k), 32'(ready), 32'd0);
      else        check("lat_ready_c10", 32'(ready), 32'd1);
      check($sformatf("lat_valid_c%0d", k), 32'(valid), (k == 9) ? 32'd1 : 32'd0);
    end

    // Back-to-back exhaustive sweep.
    for (int v = 0; v < 256; v++) convert1(8'(v));
    for (int k = 0; k < 40; k++) convert1(8'($urandom_range(255)));
`ifdef BIN_TO_BCD_BLANK_EN
    convert1(8'd7); convert1(8'd0); convert1(8'd105); convert1(8'd30);
`endif

    // start reasserted during a 200 conversion is ignored.
    wait_ready1();
    v0    = valid_cnt;
    start = 1'b1;
    bin   = 8'd200;
    ref_model(200, 3, r, o);
    q1.push_back('{bcd: r, ovf: o});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      start = (k >= 3 && k <= 9);
      if (start) bin = 8'd7;
    end
    repeat (14) @(negedge clock);
    check("reassert_single_valid", 32'(valid_cnt - v0), 32'd1);

    // Reset in cycle 4 of a 123 conversion aborts it.
    wait_ready1();
    start = 1'b1;
    bin   = 8'd123;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k == 4) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    v0 = valid_cnt;
    repeat (12) @(negedge clock);
    check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    convert1(8'd42);

    // Reset wins over start in the same cycle.
    wait_ready1();
    reset = 1'b1;
    start = 1'b1;
    bin   = 8'd9;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    check("prio_ready", 32'(ready), 32'd1);
    v0 = valid_cnt;
    repeat (12) @(negedge clock);
    check("prio_no_valid", 32'(valid_cnt - v0), 32'd0);

    // Two-digit instance: overflow truncation.
    convert2(8'd100);
    convert2(8'd99);
    convert2(8'd255);
    convert2(8'd0);
    for (int k = 0; k < 30; k++) convert2(8'($urandom_range(255)));

    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("queue1_drained", 32'(q1.size()), 32'd0);
    check("queue2_drained", 32'(q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
